imem_loader_da: RTL and testbench
=================================

# imem_loader_da

Writer-side counterpart to instruction fetch: receives a program as a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and drives the instruction memory write port at word-aligned byte addresses starting at 0. Holds the processor core in reset while a load is in progress and releases it once the last word is written. Sits between the host/debug byte link and the instruction memory that the fetch stage reads.

## Interface
- DEPTH_WORDS, 64: instruction memory capacity in 32-bit words; legal program lengths are 1..DEPTH_WORDS.
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low.
- load_req  input  1  single-cycle request to start a load; honoured only in IDLE or ERROR.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; a byte transfers on a rising edge where in_valid & in_ready.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word being written (multiple of 4).
- wr_data  output  32  assembled word.
- core_rst_n  output  1  active-low reset to the core; 0 while loading or in ERROR.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a load completes.
- err  output  1  high in ERROR.

## Operation
- Frame: 2 length bytes (N, 16-bit, high byte first), then 4*N data bytes; each word big-endian (first byte -> wr_data[31:24]).
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR.
- IDLE: in_ready=0, core_rst_n=1. load_req -> LEN_HI.
- LEN_HI: in_ready=1; on transfer latch N[15:8] -> LEN_LO.
- LEN_LO: in_ready=1; on transfer latch N[7:0]; if N==0 or N>DEPTH_WORDS -> ERROR, else -> DATA with word counter=0, byte counter=0, address=0.
- DATA: in_ready=1; each transfer shifts byte into the assembly register; on 4th byte -> WRITE.
- WRITE: in_ready=0, wr_en=1 for exactly this cycle with wr_addr=4*k, wr_data=word k. Then k+1; if k+1==N -> DONE, else -> DATA.
- DONE: one cycle, done=1, core_rst_n=1 -> IDLE.
- ERROR: in_ready=0, err=1, core_rst_n=0, no writes. load_req -> LEN_HI (err clears); otherwise stay.
- core_rst_n=0 in LEN_HI, LEN_LO, DATA, WRITE, ERROR.
- load_req outside IDLE/ERROR ignored; in_valid while in_ready=0 not consumed (byte must be held by sender).
- Word/byte counters never wrap: N<=DEPTH_WORDS guaranteed by length check; address register width 32, max value 4*(DEPTH_WORDS-1).

## Timing
- Reset (async assert, sync release on clk): state=IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_rst_n=1, busy=0, done=0, err=0.
- All outputs registered or decoded from registered state; no combinational path from in_valid to in_ready.
- load_req at edge t -> in_ready=1 and core_rst_n=0 from t+1.
- With in_valid held high: 1 cycle per byte, 5 cycles per word (4 transfers + WRITE); wr_en for word k asserted the cycle after its 4th byte transfers.
- Last WRITE at cycle w -> done=1, core_rst_n=1 at w+1; IDLE at w+2 (core_rst_n stays 1).
- Stream gaps (in_valid=0) stall indefinitely in current state with no output change.
- reset asserted mid-load: immediate return to reset values; partially assembled word discarded, core_rst_n goes 1 (memory contents undefined, host re-loads).

## Test plan
- Reset: drive reset=0 mid-DATA -> all outputs at reset values same cycle; after release state IDLE, core_rst_n=1.
- Basic load: load_req, bytes 00 02 12 34 56 78 9A BC DE F0 back-to-back -> wr_en at addr 0 data 0x12345678, then addr 4 data 0x9ABCDEF0; done pulse one cycle after second write; core_rst_n 0 from first transfer cycle to done.
- Backpressure/gaps: same frame with in_valid toggling randomly -> identical writes, in_ready low exactly during WRITE cycles, no byte lost or duplicated.
- Length errors: N=0x0000 and N=DEPTH_WORDS+1 -> err=1, no wr_en, core_rst_n=0; then load_req with valid N=1 frame -> err clears, one write, done.
- Full depth: N=DEPTH_WORDS with word k = k -> last write at addr 4*(DEPTH_WORDS-1), done once, counters no wrap.
- Ignored request: load_req pulsed during DATA -> no restart, frame completes normally.

Source files
------------

// File: rtl/imem_loader_da.sv
// Byte-stream program loader: assembles big-endian words from a length-prefixed
// frame and writes them to instruction memory while holding the core in reset.
module imem_loader_da #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_req,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  localparam logic [15:0] DEPTH16 = 16'(DEPTH_WORDS);

  state_t      state_q;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [15:0] word_cnt_q;
  logic [1:0]  byte_cnt_q;
  logic [23:0] asm_q;
  logic        in_ready_q, wr_en_q, core_rst_n_q, busy_q, done_q, err_q;
  logic [31:0] wr_addr_q, wr_data_q;

  logic        xfer;
  logic [15:0] len_rx;
  logic [15:0] word_nxt;

  // in_ready comes straight from a flop, so xfer never feeds back into in_ready.
  assign xfer     = in_valid & in_ready_q;
  assign len_rx   = {len_hi_q, in_data};
  assign word_nxt = word_cnt_q + 16'd1;

  // NOTE: every register here, including the assembly buffer, is cleared on reset
  // so a load interrupted mid-word can never leak stale bytes into the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      len_hi_q     <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      in_ready_q   <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      core_rst_n_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the defaults below make wr_en/done single-cycle
      // pulses without needing a clear in every branch.
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (load_req) begin
            state_q      <= S_LEN_HI;
            in_ready_q   <= 1'b1;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= in_data;
            state_q  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            if (len_rx == 16'd0 || len_rx > DEPTH16) begin
              state_q    <= S_ERROR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q    <= S_DATA;
              len_q      <= len_rx;
              word_cnt_q <= '0;
              byte_cnt_q <= '0;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            asm_q      <= {asm_q[15:0], in_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q    <= S_WRITE;
              in_ready_q <= 1'b0;
              wr_en_q    <= 1'b1;
              wr_data_q  <= {asm_q, in_data};
              wr_addr_q  <= {14'd0, word_cnt_q, 2'b00};
            end
          end
        end
        S_WRITE: begin
          word_cnt_q <= word_nxt;
          if (word_nxt == len_q) begin
            state_q      <= S_DONE;
            done_q       <= 1'b1;
            core_rst_n_q <= 1'b1;
          end else begin
            state_q    <= S_DATA;
            in_ready_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_ERROR: begin
          if (load_req) begin
            state_q    <= S_LEN_HI;
            err_q      <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          in_ready_q   <= 1'b0;
          core_rst_n_q <= 1'b1;
          busy_q       <= 1'b0;
          err_q        <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign core_rst_n = core_rst_n_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_imem_loader_da.sv
// Randomized bench for imem_loader_da: expected writes are derived from the raw
// byte frame, and a per-cycle monitor checks writes and output relationships.
module tb_imem_loader_da;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_req = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, wr_en, core_rst_n, busy, done, err;
  logic [31:0] wr_addr, wr_data;

  imem_loader_da #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .core_rst_n(core_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_wr_cyc = -10;
  int         done_cnt = 0;
  logic [7:0] frame_q[$];
  wr_t        exp_q[$];
  wr_t        got_log[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a legal frame produces word k = bytes[2+4k..5+4k] big-endian at 4k.
  task automatic model_expect();
    int n;
    n = {frame_q[0], frame_q[1]};
    if (n >= 1 && n <= DEPTH) begin
      for (int k = 0; k < n; k++) begin
        wr_t e;
        e.addr = 32'(4 * k);
        e.data = {frame_q[2+4*k], frame_q[3+4*k], frame_q[4+4*k], frame_q[5+4*k]};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic make_frame(input int n_field, input int nwords, input bit counting);
    logic [31:0] w;
    frame_q.delete();
    frame_q.push_back(8'(n_field >> 8));
    frame_q.push_back(8'(n_field));
    for (int k = 0; k < nwords; k++) begin
      w = counting ? 32'(k) : $urandom;
      for (int b = 3; b >= 0; b--) frame_q.push_back(w[8*b +: 8]);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (wr_en) begin
        wr_t e;
        check("wr_in_ready_low", {31'd0, in_ready}, 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_write", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        got_log.push_back('{wr_addr, wr_data});
        last_wr_cyc = cyc;
      end
      check("core_rst_n_rule", {31'd0, core_rst_n}, {31'd0, !(busy && !done)});
      if (!busy)
        check("idle_quiet", {28'd0, in_ready, wr_en, done, err}, 32'd0);
      else if (!done && !err)
        check("ready_vs_write", {31'd0, in_ready}, {31'd0, !wr_en});
      if (err) check("err_quiet", {30'd0, in_ready, wr_en}, 32'd0);
      if (done) begin
        done_cnt++;
        check("done_after_write", 32'(cyc), 32'(last_wr_cyc + 1));
        check("writes_complete", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
    check({tag, "_wr_addr"}, wr_addr, 32'd0);
    check({tag, "_wr_data"}, wr_data, 32'd0);
    check({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd1);
    check({tag, "_busy_done_err"}, {29'd0, busy, done, err}, 32'd0);
  endtask

  task automatic start_load();
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;
    check("load_in_ready", {31'd0, in_ready}, 32'd1);
    check("load_core_rst", {31'd0, core_rst_n}, 32'd0);
  endtask

  task automatic drive_bytes(input int count, input int gap_pct, input int req_at);
    int  idx = 0;
    int  guard = 0;
    bit  fired = 0;
    bit  xfer;
    while (idx < count && guard < 4000) begin
      in_data  = frame_q[idx];
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      load_req = (idx == req_at) && !fired;
      if (load_req) fired = 1;
      xfer = in_valid && in_ready;
      @(negedge clk);
      load_req = 1'b0;
      if (xfer) idx++;
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 4000) check("stream_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_frame(input int gap_pct, input int req_at, input bit expect_err);
    int g = 0;
    int d0;
    model_expect();
    d0 = done_cnt;
    start_load();
    drive_bytes(frame_q.size(), gap_pct, req_at);
    if (expect_err) begin
      repeat (3) @(negedge clk);
      check("err_set", {31'd0, err}, 32'd1);
      check("err_core_rst", {31'd0, core_rst_n}, 32'd0);
      check("err_no_done", 32'(done_cnt - d0), 32'd0);
    end else begin
      while (done !== 1'b1 && g < 400) begin
        @(negedge clk);
        g++;
      end
      if (g >= 400) check("done_timeout", 32'd0, 32'd1);
      @(negedge clk);
      check("post_done_idle", {30'd0, busy, core_rst_n}, 32'd1);
      check("frame_drained", 32'(exp_q.size()), 32'd0);
      check("done_once", 32'(done_cnt - d0), 32'd1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, back-to-back, with literal pins on the model.
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    got_log.delete();
    run_frame(0, -1, 0);
    check("basic_n_writes", 32'(got_log.size()), 32'd2);
    if (got_log.size() == 2) begin
      check("basic_addr0", got_log[0].addr, 32'h0);
      check("basic_data0", got_log[0].data, 32'h12345678);
      check("basic_addr1", got_log[1].addr, 32'h4);
      check("basic_data1", got_log[1].data, 32'h9ABCDEF0);
    end

    // Same frame with random stream gaps.
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    run_frame(50, -1, 0);

    // Length errors, a re-request from ERROR, then recovery with N=1.
    make_frame(0, 0, 0);
    run_frame(0, -1, 1);
    make_frame(DEPTH + 1, 0, 0);
    run_frame(30, -1, 1);
    make_frame(1, 1, 0);
    run_frame(20, -1, 0);
    check("recover_err_clear", {31'd0, err}, 32'd0);

    // Random lengths and data with gaps.
    for (int r = 0; r < 6; r++) begin
      make_frame(0, 0, 0);
      make_frame($urandom_range(1, 8), 0, 0);
      frame_q.delete();
      begin
        int n = $urandom_range(1, 8);
        make_frame(n, n, 0);
      end
      run_frame($urandom_range(0, 60), -1, 0);
    end

    // Ignored request in the middle of the data phase.
    make_frame(3, 3, 0);
    got_log.delete();
    run_frame(25, 6, 0);
    check("ignored_req_writes", 32'(got_log.size()), 32'd3);

    // Full depth with word k = k.
    make_frame(DEPTH, DEPTH, 1);
    got_log.delete();
    run_frame(15, -1, 0);
    check("full_n_writes", 32'(got_log.size()), 32'(DEPTH));
    if (got_log.size() == DEPTH) begin
      check("full_last_addr", got_log[DEPTH-1].addr, 32'(4 * (DEPTH - 1)));
      check("full_last_data", got_log[DEPTH-1].data, 32'(DEPTH - 1));
    end

    // Asynchronous reset in the middle of DATA.
    frame_q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    start_load();
    drive_bytes(5, 0, -1);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_vals("mid");
    exp_q.delete();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("after");

    // A clean load after the interrupted one.
    make_frame(2, 2, 0);
    run_frame(10, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
